// File: rtl/arb_resp_router.sv
// Response router for the round-robin arbiter tree: remembers the order in which requesters
// were granted and steers the single in-order response stream back to the matching master.
module arb_resp_router #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned MaxTrans  = 4,
  localparam int unsigned IdxWidth = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_sent_i,
  input  logic [IdxWidth-1:0] req_idx_i,
  output logic                trans_full_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  DataType             rsp_data_i,
  output logic [NumOut-1:0]   rsp_valid_o,
  input  logic [NumOut-1:0]   rsp_ready_i,
  output DataType             rsp_data_o [NumOut],
  output logic [IdxWidth-1:0] idx_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] outstanding_o
);

  localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  logic [IdxWidth-1:0] queue_q [MaxTrans];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic [IdxWidth-1:0] head;
  logic                push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (32'(p) == MaxTrans - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty_o       = (count_q == '0);
  assign trans_full_o  = (count_q == CntWidth'(MaxTrans));
  assign outstanding_o = count_q;
  assign head          = queue_q[rd_ptr_q];
  assign idx_o         = empty_o ? '0 : head;

  assign push = req_sent_i & ~trans_full_o;
  assign pop  = rsp_valid_i & rsp_ready_o;

  // An out-of-range head swallows its response so a bad index cannot wedge the slave port.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (NumOut == 1) begin
      rsp_valid_o[0] = rsp_valid_i & ~empty_o;
      rsp_ready_o    = rsp_ready_i[0] & ~empty_o;
    end else if (!empty_o) begin
      if (32'(head) < NumOut) begin
        rsp_valid_o[head] = rsp_valid_i;
        rsp_ready_o       = rsp_ready_i[head];
      end else begin
        rsp_ready_o = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumOut; k++) begin
      rsp_data_o[k] = rsp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue entries are pure data; stale contents are never observed because count gates them.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) queue_q[wr_ptr_q] <= req_idx_i;
  end

`ifdef ARB_RESP_ROUTER_ASSERTS
  // Upstream protocol checks; the datapath still behaves deterministically when they fire.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(req_sent_i && trans_full_o)) else $error("push while tracking queue full");
      assert (!(req_sent_i && (32'(req_idx_i) >= NumOut))) else $error("request index out of range");
      assert (!(rsp_valid_i && empty_o)) else $error("response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed bench for arb_resp_router: a cycle table on a 4x4 instance plus a pointer-wrap
// sequence on a 4-output, 3-deep instance.
module tb_arb_resp_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NumOut=4, MaxTrans=4
  logic        rst_n, a_flush, a_sent, a_vld, a_rdy_o, a_full, a_empty;
  logic [1:0]  a_idx, a_idx_o;
  logic [3:0]  a_rdy, a_vld_o;
  logic [31:0] a_data;
  logic [31:0] a_data_o [4];
  logic [2:0]  a_out;

  arb_resp_router #(.NumOut(4), .DataWidth(32), .MaxTrans(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .req_sent_i(a_sent), .req_idx_i(a_idx), .trans_full_o(a_full),
    .rsp_valid_i(a_vld), .rsp_ready_o(a_rdy_o), .rsp_data_i(a_data),
    .rsp_valid_o(a_vld_o), .rsp_ready_i(a_rdy), .rsp_data_o(a_data_o),
    .idx_o(a_idx_o), .empty_o(a_empty), .outstanding_o(a_out)
  );

  // Instance B: NumOut=4, MaxTrans=3 (non power-of-two depth)
  logic        b_flush, b_sent, b_vld, b_rdy_o, b_full, b_empty;
  logic [1:0]  b_idx, b_idx_o, b_out;
  logic [3:0]  b_rdy, b_vld_o;
  logic [31:0] b_data;
  logic [31:0] b_data_o [4];

  arb_resp_router #(.NumOut(4), .DataWidth(32), .MaxTrans(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .req_sent_i(b_sent), .req_idx_i(b_idx), .trans_full_o(b_full),
    .rsp_valid_i(b_vld), .rsp_ready_o(b_rdy_o), .rsp_data_i(b_data),
    .rsp_valid_o(b_vld_o), .rsp_ready_i(b_rdy), .rsp_data_o(b_data_o),
    .idx_o(b_idx_o), .empty_o(b_empty), .outstanding_o(b_out)
  );

  typedef struct {
    logic       rst_n, flush, sent;
    logic [1:0] idx;
    logic       vld;
    logic [3:0] rdy;
    logic [3:0] e_vld;
    logic       e_rdy, e_full, e_empty;
    logic [2:0] e_out;
    logic [1:0] e_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, input logic f, input logic s, input logic [1:0] i,
                     input logic v, input logic [3:0] rd, input logic [3:0] ev,
                     input logic er, input logic ef, input logic ee,
                     input logic [2:0] eo, input logic [1:0] ei);
    vec_t t;
    t.rst_n = r; t.flush = f; t.sent = s; t.idx = i; t.vld = v; t.rdy = rd;
    t.e_vld = ev; t.e_rdy = er; t.e_full = ef; t.e_empty = ee; t.e_out = eo; t.e_idx = ei;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq [8];

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_sent = 0; a_idx = 0; a_vld = 0; a_rdy = 4'hF; a_data = '0;
    b_flush = 0; b_sent = 0; b_idx = 0; b_vld = 0; b_rdy = 4'hF; b_data = '0;

    //   rst fl snt idx vld rdy     e_vld    rdy full emp out idx
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);  // reset state
    row(1, 0, 0, 0, 1, 4'hF,    4'b0000, 0, 0, 1, 0, 0);  // response while empty stalls
    row(1, 0, 1, 2, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 0, 0, 4'hF,    4'b0000, 1, 0, 0, 1, 2);
    row(1, 0, 1, 3, 0, 4'hF,    4'b0000, 1, 0, 0, 2, 2);
    row(1, 0, 0, 0, 1, 4'hF,    4'b0100, 1, 0, 0, 3, 2);
    row(1, 0, 0, 0, 1, 4'hF,    4'b0001, 1, 0, 0, 2, 0);
    row(1, 0, 0, 0, 1, 4'hF,    4'b1000, 1, 0, 0, 1, 3);
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 1, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);  // fill 1,1,2,3
    row(1, 0, 1, 1, 0, 4'hF,    4'b0000, 1, 0, 0, 1, 1);
    row(1, 0, 1, 2, 0, 4'hF,    4'b0000, 1, 0, 0, 2, 1);
    row(1, 0, 1, 3, 0, 4'hF,    4'b0000, 1, 0, 0, 3, 1);
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 1, 1, 0, 4, 1);  // full
    row(1, 0, 1, 0, 1, 4'hF,    4'b0010, 1, 1, 0, 4, 1);  // push while full dropped, pop
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 1, 0, 0, 3, 1);
    row(1, 0, 0, 0, 1, 4'hF,    4'b0010, 1, 0, 0, 3, 1);  // -> {2,3}
    row(1, 0, 1, 0, 1, 4'hF,    4'b0100, 1, 0, 0, 2, 2);  // push+pop at 2 -> {3,0}
    row(1, 0, 1, 1, 1, 4'hF,    4'b1000, 1, 0, 0, 2, 3);  // -> {0,1}
    row(1, 0, 0, 0, 1, 4'hF,    4'b0001, 1, 0, 0, 2, 0);  // -> {1}
    row(1, 0, 0, 0, 1, 4'h0,    4'b0010, 0, 0, 0, 1, 1);  // backpressure x3
    row(1, 0, 0, 0, 1, 4'h0,    4'b0010, 0, 0, 0, 1, 1);
    row(1, 0, 0, 0, 1, 4'h0,    4'b0010, 0, 0, 0, 1, 1);
    row(1, 0, 0, 0, 1, 4'b0010, 4'b0010, 1, 0, 0, 1, 1);
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 1, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 2, 0, 4'hF,    4'b0000, 1, 0, 0, 1, 1);
    row(1, 0, 1, 3, 0, 4'hF,    4'b0000, 1, 0, 0, 2, 1);
    row(1, 1, 1, 0, 0, 4'hF,    4'b0000, 1, 0, 0, 3, 1);  // flush with push, pre-flush view
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 2, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);
    row(1, 0, 1, 3, 0, 4'hF,    4'b0000, 1, 0, 0, 1, 2);
    row(0, 0, 0, 0, 0, 4'hF,    4'b0000, 1, 0, 0, 2, 2);  // reset with 2 outstanding
    row(1, 0, 0, 0, 0, 4'hF,    4'b0000, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      rst_n = vecs[n].rst_n; a_flush = vecs[n].flush; a_sent = vecs[n].sent;
      a_idx = vecs[n].idx; a_vld = vecs[n].vld; a_rdy = vecs[n].rdy;
      a_data = 32'hC0DE_0000 + 32'(n);
      @(negedge clk);
      chk("rsp_valid_o", n, 32'(a_vld_o), 32'(vecs[n].e_vld));
      chk("rsp_ready_o", n, 32'(a_rdy_o), 32'(vecs[n].e_rdy));
      chk("trans_full_o", n, 32'(a_full), 32'(vecs[n].e_full));
      chk("empty_o", n, 32'(a_empty), 32'(vecs[n].e_empty));
      chk("outstanding_o", n, 32'(a_out), 32'(vecs[n].e_out));
      chk("idx_o", n, 32'(a_idx_o), 32'(vecs[n].e_idx));
      for (int k = 0; k < 4; k++) chk("rsp_data_o", n, a_data_o[k], 32'hC0DE_0000 + 32'(n));
      step();
    end
    rst_n = 1'b1; a_sent = 0; a_vld = 0; a_flush = 0;

    // Pointer wrap on the 3-deep instance: keep one entry in flight, push and pop each cycle.
    seq[0] = 2'd3; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0;
    seq[4] = 2'd3; seq[5] = 2'd2; seq[6] = 2'd1; seq[7] = 2'd0;
    b_sent = 1; b_idx = seq[0]; b_vld = 0;
    step();
    for (int i = 1; i < 8; i++) begin
      b_sent = 1; b_idx = seq[i]; b_vld = 1; b_data = 32'hB000_0000 + 32'(i);
      @(negedge clk);
      chk("wrap_valid", i, 32'(b_vld_o), 32'(4'b0001 << seq[i-1]));
      chk("wrap_outstanding", i, 32'(b_out), 32'd1);
      chk("wrap_data", i, b_data_o[seq[i-1]], 32'hB000_0000 + 32'(i));
      step();
    end
    b_sent = 0; b_vld = 1;
    @(negedge clk);
    chk("wrap_last_valid", 8, 32'(b_vld_o), 32'(4'b0001 << seq[7]));
    step();
    b_vld = 0;
    @(negedge clk);
    chk("wrap_empty", 9, 32'(b_empty), 32'd1);

    // Fill the 3-deep instance, then a push while full (no pop) must be dropped.
    for (int i = 0; i < 4; i++) begin
      step();
      b_sent = 1; b_idx = 2'(i);
    end
    step();
    b_sent = 0;
    @(negedge clk);
    chk("b_full", 10, 32'(b_full), 32'd1);
    chk("b_outstanding_full", 10, 32'(b_out), 32'd3);
    chk("b_head_after_fill", 10, 32'(b_idx_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_resp_router.md
# arb_resp_router

Response-side counterpart of the round-robin arbitration tree. It records the index of every requester whose request has been granted downstream in an in-order tracking queue. It then routes the single returning response stream back to that requester as a one-hot valid/ready demultiplexer. It sits between a shared in-order slave port and the N masters that the arbiter tree multiplexes onto it.

## Interface
Parameters:
- NumOut, 4: number of masters / response outputs (≥1)
- DataWidth, 32: response payload width
- DataType, logic [DataWidth-1:0]: response payload type
- MaxTrans, 4: maximum outstanding transactions, i.e. tracking queue depth (≥1; any value, not necessarily a power of two)
- Derived localparams:
  - IdxWidth = (NumOut > 1) ? $clog2(NumOut) : 1
  - CntWidth = $clog2(MaxTrans+1)

Ports:
- clk_i  in  1  clock; one clock domain, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous clear of all tracked transactions
- req_sent_i  in  1  a request was handed downstream this cycle (arbiter req_o & gnt_i)
- req_idx_i  in  IdxWidth  index of the granted requester (arbiter idx_o)
- trans_full_o  out  1  queue full; upstream must gate the arbiter's gnt_i with ~trans_full_o
- rsp_valid_i  in  1  response valid from slave
- rsp_ready_o  out  1  response accepted
- rsp_data_i  in  DataType  response payload
- rsp_valid_o  out  NumOut  one-hot response valid per master
- rsp_ready_i  in  NumOut  per-master ready
- rsp_data_o  out  DataType[NumOut]  payload broadcast to all masters
- idx_o  out  IdxWidth  index at queue head (0 when empty)
- empty_o  out  1  no outstanding transaction
- outstanding_o  out  CntWidth  number of tracked transactions

## Operation
- Circular queue of MaxTrans entries with IdxWidth bits each. It has a write pointer, a read pointer and an occupancy count.
- Pointers wrap from MaxTrans-1 to 0.
- Push:
  - Happens when req_sent_i=1 and trans_full_o=0; req_idx_i is stored at the write pointer.
  - If req_sent_i=1 while full, the push is dropped, even when a pop happens in the same cycle. Assertion: req_sent_i |-> !trans_full_o.
- Routing, when empty_o=0 and H = head entry:
  - rsp_valid_o[H] = rsp_valid_i; all other bits are 0.
  - rsp_ready_o = rsp_ready_i[H].
  - rsp_data_o[k] = rsp_data_i for every k.
- Pop happens when rsp_valid_i & rsp_ready_o; the read pointer advances.
- Out-of-range head (H ≥ NumOut):
  - rsp_valid_o = '0 and rsp_ready_o = 1, so the response is consumed and dropped. This prevents deadlock.
  - Assertion: req_sent_i |-> req_idx_i < NumOut.
- Empty queue:
  - rsp_valid_o = '0 and rsp_ready_o = 0, so the response stalls.
  - Assertion: rsp_valid_i |-> !empty_o.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Priority per cycle: rst_ni=0 first, then flush_i, then push/pop.
  - Flush clears pointers and count on the next edge.
  - Any push or pop in a flush cycle is discarded.
  - Combinational outputs in the flush cycle still reflect the pre-flush state.
- Status outputs:
  - trans_full_o = (count == MaxTrans)
  - empty_o = (count == 0)
  - outstanding_o = count
- NumOut=1: rsp_valid_o[0] = rsp_valid_i & ~empty_o; queue contents are ignored but still counted.

## Timing
- Reset values (same on flush, one cycle later):
  - rsp_valid_o = '0
  - rsp_ready_o = 0
  - trans_full_o = 0
  - empty_o = 1
  - outstanding_o = 0
  - idx_o = 0
- No combinational path from req_sent_i or req_idx_i to any output. A push becomes visible at the next edge.
- Consequence: a response cannot be routed in the same cycle as its request push. The minimum request-to-response latency is 1 cycle, and the slave must honour this.
- Combinational paths:
  - rsp_valid_i → rsp_valid_o
  - rsp_ready_i → rsp_ready_o
  - rsp_data_i → rsp_data_o
- These paths have zero latency and no added register. rsp_valid_o must not depend on rsp_ready_i.
- Handshakes follow AXI valid/ready rules:
  - Once rsp_valid_i is asserted, the routed rsp_valid_o stays stable until the handshake.
  - This holds because the head only changes on pop or flush.
- trans_full_o rises at the edge that completes the MaxTrans-th push. It falls at the edge after a pop from full.

## Test plan
- Reset then idle, with rsp_ready_i all 1:
  - Outputs are at reset values.
  - rsp_valid_i=1 with the queue empty → rsp_ready_o=0 and rsp_valid_o=0000.
- NumOut=4, MaxTrans=4; push idx 2, 0, 3 on consecutive cycles, then 3 responses with rsp_ready_i=1111:
  - rsp_valid_o = 0100, then 0001, then 1000.
  - outstanding_o goes 3, 2, 1, 0; empty_o=1 after the last response.
- Fill to 4 entries:
  - trans_full_o=1.
  - A 5th push in the same cycle as a pop is dropped, leaving outstanding_o=3.
  - Push/pop in the same cycle at count 2 keeps count 2 and routes in order.
- Backpressure: head idx 1, rsp_valid_i=1, rsp_ready_i=0000 for 3 cycles:
  - rsp_valid_o=0010 held and rsp_ready_o=0, with no pop.
  - rsp_ready_i=0010 → pop and outstanding_o decrements by 1.
- MaxTrans=3: run 7 push/pop pairs to exercise pointer wrap. Routed indices must match the pushed sequence exactly.
- Flush and reset mid-operation:
  - With 3 outstanding, flush_i=1 together with req_sent_i=1 → next cycle outstanding_o=0 and empty_o=1.
  - With 2 outstanding, rst_ni=0 for one edge → all outputs at reset values.
